// File: rtl/vec_insn_dispatcher.sv
// vec_insn_dispatcher
// Holds vector instructions from the issue stage in an in-order FIFO and sends
// them to the vector accelerator only once they are committed. It caps how many
// accelerator ops can be in flight, registers accelerator responses onto the
// writeback port, and handles the fence (drain) and flush controls.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   issue_*                   valid/ready instruction intake (insn, rs1, rs2, trans_id)
//   commit_i                  commits the oldest speculative entry
//   flush_i                   drops every speculative entry
//   fence_i / fence_done_o    drain request / one-cycle drain-complete pulse
//   acc_req_*                 valid/ready request to the accelerator (head entry)
//   acc_resp_*                accelerator result, no back-pressure
//   wb_*                      registered writeback, one cycle after the response
//   busy_o                    FIFO non-empty or accelerator ops in flight
//
// Optional build macro VEC_DISPATCH_PERF_CNT_EN adds perf_dispatched_o and
// perf_stall_o, two 32-bit wrapping event counters.
//
// FSM states:
//   state | meaning
//   RUN   | normal operation, new instructions accepted
//   FENCE | intake blocked until the FIFO is empty and no ops are outstanding

module vec_insn_dispatcher #(
  parameter int unsigned NrEntries      = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TransIdWidth   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [31:0]             issue_insn_i,
  input  logic [XLEN-1:0]         issue_rs1_i,
  input  logic [XLEN-1:0]         issue_rs2_i,
  input  logic [TransIdWidth-1:0] issue_trans_id_i,
  input  logic                    commit_i,
  input  logic                    flush_i,
  input  logic                    fence_i,
  output logic                    fence_done_o,
  output logic                    acc_req_valid_o,
  input  logic                    acc_req_ready_i,
  output logic [31:0]             acc_req_insn_o,
  output logic [XLEN-1:0]         acc_req_rs1_o,
  output logic [XLEN-1:0]         acc_req_rs2_o,
  output logic [TransIdWidth-1:0] acc_req_trans_id_o,
  input  logic                    acc_resp_valid_i,
  input  logic [XLEN-1:0]         acc_resp_result_i,
  input  logic [TransIdWidth-1:0] acc_resp_trans_id_i,
  input  logic                    acc_resp_exception_i,
  output logic                    wb_valid_o,
  output logic [XLEN-1:0]         wb_result_o,
  output logic [TransIdWidth-1:0] wb_trans_id_o,
  output logic                    wb_exception_o,
`ifdef VEC_DISPATCH_PERF_CNT_EN
  output logic [31:0]             perf_dispatched_o,
  output logic [31:0]             perf_stall_o,
`endif
  output logic                    busy_o
);

  localparam int unsigned IdxW = $clog2(NrEntries);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {RUN, FENCE} state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] commit_q, commit_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic            init_q;

  logic [31:0]             insn_mem  [NrEntries];
  logic [XLEN-1:0]         rs1_mem   [NrEntries];
  logic [XLEN-1:0]         rs2_mem   [NrEntries];
  logic [TransIdWidth-1:0] id_mem    [NrEntries];

  logic                    wb_valid_q;
  logic [XLEN-1:0]         wb_result_q;
  logic [TransIdWidth-1:0] wb_id_q;
  logic                    wb_exc_q;

  logic full, empty, has_committed, below_limit;
  logic enq, fire, commit_ok, resp_ok, drained;
  logic [IdxW-1:0] head_idx, tail_idx;

  assign head_idx      = head_q[IdxW-1:0];
  assign tail_idx      = tail_q[IdxW-1:0];
  assign full          = (head_q[PtrW-1] != tail_q[PtrW-1]) && (head_idx == tail_idx);
  assign empty         = (head_q == tail_q);
  assign has_committed = (head_q != commit_q);
  assign below_limit   = (outst_q < CntW'(MaxOutstanding));

  // init_q keeps issue_ready_o low while reset is asserted and releases it one
  // clock after reset deasserts.
  assign issue_ready_o   = init_q && !full && (state_q == RUN) && !flush_i;
  assign enq             = issue_valid_i && issue_ready_o;
  assign acc_req_valid_o = has_committed && below_limit;
  assign fire            = acc_req_valid_o && acc_req_ready_i;
  assign commit_ok       = commit_i && (commit_q != tail_q);
  // A response that arrives with nothing outstanding is stale, for example one
  // left over from before a reset. It is dropped and never reaches writeback.
  assign resp_ok         = acc_resp_valid_i && (outst_q != '0);
  assign drained         = empty && (outst_q == '0);

  // The request data is forced to zero while no request is valid, so reset
  // clears it together with the other outputs.
  assign acc_req_insn_o     = acc_req_valid_o ? insn_mem[head_idx] : '0;
  assign acc_req_rs1_o      = acc_req_valid_o ? rs1_mem[head_idx]  : '0;
  assign acc_req_rs2_o      = acc_req_valid_o ? rs2_mem[head_idx]  : '0;
  assign acc_req_trans_id_o = acc_req_valid_o ? id_mem[head_idx]   : '0;

  assign wb_valid_o     = wb_valid_q;
  assign wb_result_o    = wb_result_q;
  assign wb_trans_id_o  = wb_id_q;
  assign wb_exception_o = wb_exc_q;
  assign busy_o         = !empty || (outst_q != '0);

  always_comb begin
    head_d   = head_q + PtrW'(fire);
    commit_d = commit_q + PtrW'(commit_ok);
    tail_d   = tail_q;
    // A flush snaps tail back to the commit pointer after this cycle's commit
    // has been applied, so an entry committed in the same cycle is kept.
    if (flush_i) begin
      tail_d = commit_d;
    end else if (enq) begin
      tail_d = tail_q + PtrW'(1);
    end
    outst_d = outst_q + CntW'(fire) - CntW'(resp_ok);
  end

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    case (state_q)
      RUN: begin
        if (fence_i) state_d = FENCE;
      end
      FENCE: begin
        if (drained) begin
          fence_done_o = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      head_q      <= '0;
      commit_q    <= '0;
      tail_q      <= '0;
      outst_q     <= '0;
      init_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_id_q     <= '0;
      wb_exc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      commit_q   <= commit_d;
      tail_q     <= tail_d;
      outst_q    <= outst_d;
      init_q     <= 1'b1;
      wb_valid_q <= resp_ok;
      if (resp_ok) begin
        wb_result_q <= acc_resp_result_i;
        wb_id_q     <= acc_resp_trans_id_i;
        wb_exc_q    <= acc_resp_exception_i;
      end
    end
  end

  // The payload storage has no reset. An entry is only ever read after it has
  // been written, and the request outputs are zeroed while no request is valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      insn_mem[tail_idx] <= issue_insn_i;
      rs1_mem[tail_idx]  <= issue_rs1_i;
      rs2_mem[tail_idx]  <= issue_rs2_i;
      id_mem[tail_idx]   <= issue_trans_id_i;
    end
  end

`ifdef VEC_DISPATCH_PERF_CNT_EN
  logic [31:0] perf_disp_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire) perf_disp_q <= perf_disp_q + 32'd1;
      // A stall is a cycle with a committed head that does not dispatch,
      // whether the accelerator is not ready or the outstanding limit is hit.
      if (has_committed && !fire) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_dispatched_o = perf_disp_q;
  assign perf_stall_o      = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_insn_dispatcher.sv
module tb_vec_insn_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_insn_i = '0;
  logic [63:0] issue_rs1_i = '0, issue_rs2_i = '0;
  logic [2:0]  issue_trans_id_i = '0;
  logic        commit_i = 1'b0, flush_i = 1'b0, fence_i = 1'b0;
  logic        fence_done_o;
  logic        acc_req_valid_o;
  logic        acc_req_ready_i = 1'b1;
  logic [31:0] acc_req_insn_o;
  logic [63:0] acc_req_rs1_o, acc_req_rs2_o;
  logic [2:0]  acc_req_trans_id_o;
  logic        acc_resp_valid_i = 1'b0;
  logic [63:0] acc_resp_result_i = '0;
  logic [2:0]  acc_resp_trans_id_i = '0;
  logic        acc_resp_exception_i = 1'b0;
  logic        wb_valid_o;
  logic [63:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic        wb_exception_o;
  logic        busy_o;
`ifdef VEC_DISPATCH_PERF_CNT_EN
  logic [31:0] perf_dispatched_o, perf_stall_o;
`endif

  int compared = 0;
  int mismatched = 0;

  vec_insn_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_trans_id_i(issue_trans_id_i),
    .commit_i(commit_i), .flush_i(flush_i), .fence_i(fence_i), .fence_done_o(fence_done_o),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_insn_o(acc_req_insn_o), .acc_req_rs1_o(acc_req_rs1_o),
    .acc_req_rs2_o(acc_req_rs2_o), .acc_req_trans_id_o(acc_req_trans_id_o),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_result_i(acc_resp_result_i),
    .acc_resp_trans_id_i(acc_resp_trans_id_i), .acc_resp_exception_i(acc_resp_exception_i),
    .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_exception_o(wb_exception_o),
`ifdef VEC_DISPATCH_PERF_CNT_EN
    .perf_dispatched_o(perf_dispatched_o), .perf_stall_o(perf_stall_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: an in-order queue ----------------
  typedef struct {
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  id;
  } ent_t;

  ent_t        q[$];        // oldest first; the first ncom entries are committed
  int          ncom = 0;
  int          outst = 0;
  bit          fencing = 0;
  bit          started = 0;
  bit          m_wbv = 0;
  logic [63:0] m_wbr = '0;
  logic [2:0]  m_wbid = '0;
  bit          m_wbe = 0;

  function automatic bit m_ready();
    return started && (q.size() < 4) && !fencing && !flush_i;
  endfunction
  function automatic bit m_valid();
    return (ncom > 0) && (outst < 2);
  endfunction
  function automatic bit m_done();
    return fencing && (q.size() == 0) && (outst == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ncom = 0; outst = 0; fencing = 0; started = 0;
      m_wbv = 0; m_wbr = '0; m_wbid = '0; m_wbe = 0;
    end else begin : upd
      bit fire, rok, done, acc;
      ent_t e;
      fire = m_valid() && acc_req_ready_i;
      rok  = acc_resp_valid_i && (outst > 0);
      done = m_done();
      acc  = issue_valid_i && m_ready();
      m_wbv = rok;
      if (rok) begin
        m_wbr = acc_resp_result_i; m_wbid = acc_resp_trans_id_i; m_wbe = acc_resp_exception_i;
      end
      if (commit_i) begin
        compared++;
        if (ncom < q.size()) ncom++;
        else begin
          mismatched++;
          $display("FAIL commit_legal: got commit with %0d committed of %0d entries", ncom, q.size());
        end
      end
      if (fire) begin
        void'(q.pop_front());
        ncom--;
        outst++;
      end
      if (rok) outst--;
      if (flush_i) begin
        while (q.size() > ncom) void'(q.pop_back());
      end else if (acc) begin
        e.insn = issue_insn_i; e.rs1 = issue_rs1_i; e.rs2 = issue_rs2_i; e.id = issue_trans_id_i;
        q.push_back(e);
      end
      if (fencing) begin
        if (done) fencing = 0;
      end else if (fence_i) begin
        fencing = 1;
      end
      started = 1;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    chk("issue_ready", issue_ready_o, m_ready());
    chk("acc_req_valid", acc_req_valid_o, m_valid());
    if (m_valid() && acc_req_valid_o) begin
      chk("acc_req_insn", acc_req_insn_o, q[0].insn);
      chk("acc_req_rs1", acc_req_rs1_o, q[0].rs1);
      chk("acc_req_rs2", acc_req_rs2_o, q[0].rs2);
      chk("acc_req_id", acc_req_trans_id_o, q[0].id);
    end
    chk("fence_done", fence_done_o, m_done());
    chk("busy", busy_o, (q.size() > 0) || (outst > 0));
    chk("wb_valid", wb_valid_o, m_wbv);
    if (m_wbv && wb_valid_o) begin
      chk("wb_result", wb_result_o, m_wbr);
      chk("wb_id", wb_trans_id_o, m_wbid);
      chk("wb_exc", wb_exception_o, m_wbe);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
    issue_valid_i = 0; commit_i = 0; flush_i = 0; fence_i = 0; acc_resp_valid_i = 0;
  endtask

  task automatic issue(input logic [2:0] id, input logic [31:0] insn);
    issue_valid_i = 1; issue_trans_id_i = id; issue_insn_i = insn;
    issue_rs1_i = {32'hA5A5_0000, insn}; issue_rs2_i = {insn, 29'h0, id};
    cyc();
  endtask

  task automatic commit1();
    commit_i = 1;
    cyc();
  endtask

  task automatic resp(input logic [2:0] id, input logic [63:0] res, input logic exc);
    acc_resp_valid_i = 1; acc_resp_trans_id_i = id; acc_resp_result_i = res;
    acc_resp_exception_i = exc;
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1;
    chk("pre_release_ready", issue_ready_o, 0);
    cyc();
    chk("post_release_ready", issue_ready_o, 1);

    // 1: issue, commit, dispatch, response, writeback
    issue(3'd3, 32'h0200_0057);
    commit1();
    chk("t1_req_valid", acc_req_valid_o, 1);
    chk("t1_req_id", acc_req_trans_id_o, 3);
    chk("t1_req_insn", acc_req_insn_o, 32'h0200_0057);
    cyc();
    chk("t1_req_gone", acc_req_valid_o, 0);
    resp(3'd3, 64'hDEAD, 0);
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_wb_result", wb_result_o, 64'hDEAD);
    chk("t1_wb_id", wb_trans_id_o, 3);
    cyc();
    chk("t1_wb_once", wb_valid_o, 0);
    chk("t1_idle", busy_o, 0);

    // 2: fill without commit, then commit one
    for (int i = 0; i < 4; i++) issue(3'(i), 32'h1000_0057 + 32'(i));
    chk("t2_full_ready", issue_ready_o, 0);
    chk("t2_no_req", acc_req_valid_o, 0);
    commit1();
    chk("t2_req_valid", acc_req_valid_o, 1);
    chk("t2_req_id", acc_req_trans_id_o, 0);
    cyc();
    chk("t2_one_only", acc_req_valid_o, 0);
    chk("t2_ready_back", issue_ready_o, 1);
    resp(3'd0, 64'h1234, 1);
    chk("t2_wb_exc", wb_exception_o, 1);
    flush_i = 1;
    cyc();
    chk("t2_flushed", busy_o, 0);

    // 3: flush together with a fourth issue
    issue(3'd4, 32'h2000_0057);
    issue(3'd5, 32'h2100_0057);
    issue(3'd6, 32'h2200_0057);
    commit1();
    chk("t3_req_id", acc_req_trans_id_o, 4);
    flush_i = 1; issue_valid_i = 1; issue_trans_id_i = 3'd7; issue_insn_i = 32'h2300_0057;
    #1 chk("t3_flush_blocks", issue_ready_o, 0);
    cyc();
    chk("t3_no_req", acc_req_valid_o, 0);
    chk("t3_busy", busy_o, 1);
    resp(3'd4, 64'h4444, 0);
    chk("t3_wb_id", wb_trans_id_o, 4);
    chk("t3_idle", busy_o, 0);

    // 3b: commit in the same cycle as flush keeps the committed entry
    acc_req_ready_i = 0;
    issue(3'd1, 32'h3000_0057);
    issue(3'd2, 32'h3100_0057);
    commit_i = 1; flush_i = 1;
    cyc();
    chk("t3b_survivor", acc_req_valid_o, 1);
    chk("t3b_survivor_id", acc_req_trans_id_o, 1);
    cyc();
    chk("t3b_held_id", acc_req_trans_id_o, 1);
    acc_req_ready_i = 1;
    cyc();
    chk("t3b_only_one", acc_req_valid_o, 0);
    resp(3'd1, 64'h5555, 0);
    chk("t3b_idle", busy_o, 0);

    // 4: outstanding limit
    acc_req_ready_i = 0;
    for (int i = 0; i < 3; i++) issue(3'(i), 32'h4000_0057 + 32'(i << 8));
    repeat (3) commit1();
    acc_req_ready_i = 1;
    cyc();
    cyc();
    chk("t4_limit", acc_req_valid_o, 0);
    chk("t4_busy", busy_o, 1);
    resp(3'd0, 64'h10, 0);
    chk("t4_third", acc_req_valid_o, 1);
    chk("t4_third_id", acc_req_trans_id_o, 2);
    cyc();
    chk("t4_drained_q", acc_req_valid_o, 0);
    resp(3'd1, 64'h11, 0);
    resp(3'd2, 64'h12, 0);
    chk("t4_idle", busy_o, 0);

    // 5: fence with one queued and one outstanding
    acc_req_ready_i = 0;
    issue(3'd1, 32'h5000_0057);
    commit1();
    acc_req_ready_i = 1;
    cyc();
    acc_req_ready_i = 0;
    issue(3'd2, 32'h5100_0057);
    commit1();
    fence_i = 1;
    cyc();
    chk("t5_fence_ready", issue_ready_o, 0);
    chk("t5_no_done", fence_done_o, 0);
    acc_req_ready_i = 1;
    fence_i = 1;
    cyc();
    chk("t5_still_fence", issue_ready_o, 0);
    resp(3'd1, 64'h21, 0);
    chk("t5_wait", fence_done_o, 0);
    resp(3'd2, 64'h22, 0);
    chk("t5_done", fence_done_o, 1);
    cyc();
    chk("t5_done_pulse", fence_done_o, 0);
    chk("t5_ready_back", issue_ready_o, 1);
    fence_i = 1;
    cyc();
    chk("t5_idle_done", fence_done_o, 1);
    cyc();
    chk("t5_idle_pulse", fence_done_o, 0);

    // 6: reset while busy
    issue(3'd5, 32'h6000_0057);
    commit1();
    cyc();
    issue(3'd6, 32'h6100_0057);
    commit1();
    cyc();
    issue(3'd7, 32'h6200_0057);
    commit1();
    chk("t6_limit", acc_req_valid_o, 0);
    chk("t6_busy", busy_o, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", acc_req_valid_o, 0);
    chk("t6_rst_ready", issue_ready_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_wb", wb_valid_o, 0);
    chk("t6_rst_id", acc_req_trans_id_o, 0);
    chk("t6_rst_done", fence_done_o, 0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc();
    resp(3'd5, 64'h99, 0);
    chk("t6_stale_wb", wb_valid_o, 0);
    resp(3'd6, 64'h98, 0);
    chk("t6_stale_wb2", wb_valid_o, 0);
    chk("t6_idle", busy_o, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
